// File: rtl/flit_decompressor.sv
// Rebuilds a full flit from a base+delta compressed payload (LANES chunks per
// cycle) or passes a raw flit straight through, with valid/ready on both sides.
module flit_decompressor #(
    parameter int unsigned NUM_OF_BITS = 128,
    parameter int unsigned CHUNK_SIZE  = 8,
    parameter int unsigned EN_BITS     = 3,
    parameter int unsigned LANES       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_compressed,
    input  logic [NUM_OF_BITS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OF_BITS-1:0] out_data
);

    localparam int unsigned NUM_CHUNKS = NUM_OF_BITS / CHUNK_SIZE;
    localparam int unsigned GROUPS     = NUM_CHUNKS / LANES;
    localparam int unsigned CNT_W      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned DELTA_W    = NUM_CHUNKS * EN_BITS;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHUNK_SIZE-1:0]  base_q, base_d;
    logic [DELTA_W-1:0]     deltas_q, deltas_d;
    logic [NUM_OF_BITS-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   accept;

    // A new flit can enter from IDLE, or from HOLD in the same cycle the held one leaves.
    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state logic: accept/handoff in IDLE/HOLD, one chunk group per cycle in EXPAND.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        deltas_d = deltas_q;
        data_d   = data_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE, S_HOLD: begin
                // Handoff: the held flit leaves; out_data is intentionally kept.
                if ((state_q == S_HOLD) && out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
                if (accept) begin
                    if (in_compressed) begin
                        base_d   = in_data[CHUNK_SIZE-1:0];
                        deltas_d = in_data[CHUNK_SIZE +: DELTA_W];
                        cnt_d    = '0;
                        state_d  = S_EXPAND;
                        valid_d  = 1'b0;
                    end else begin
                        data_d   = in_data;
                        state_d  = S_HOLD;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_EXPAND: begin
                for (int c = 0; c < int'(NUM_CHUNKS); c++) begin
                    if (CNT_W'(c / int'(LANES)) == cnt_q) begin
                        data_d[c*CHUNK_SIZE +: CHUNK_SIZE] =
                            base_q + CHUNK_SIZE'(deltas_q[c*EN_BITS +: EN_BITS]);
                    end
                end
                if (cnt_q == LAST_GRP) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial or pending flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            deltas_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            deltas_q <= deltas_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_flit_decompressor.sv
// Directed bench for flit_decompressor: expected flits are queued at accept
// time and a negedge monitor compares every completed output handshake.
module tb_flit_decompressor;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_compressed;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic [127:0] exp_q[$];
    int           n_cmp;
    int           n_err;

    flit_decompressor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_compressed(in_compressed),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base, input logic [47:0] d,
                                         input logic [71:0] upper);
        return {upper, d, base};
    endfunction

    // Scoreboard monitor: every output handshake must match the oldest expected flit.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: unexpected flit %h", out_data);
            end else begin
                check("scoreboard", out_data, exp_q.pop_front());
            end
        end
    end

    // Call at posedge+#1; returns at accept edge +#1 with the number of extra cycles waited.
    task automatic send(input logic comp, input logic [127:0] data, input logic [127:0] exp,
                        output int waits);
        int budget;
        in_valid      = 1'b1;
        in_compressed = comp;
        in_data       = data;
        waits         = 0;
        budget        = 50;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            waits++;
            budget--;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready %b required 1", in_ready);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [47:0]  d_basic;
        logic [127:0] hold_val;
        int           w;
        int           budget;

        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_compressed = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        for (int i = 0; i < 16; i++) d_basic[i*3 +: 3] = 3'(i % 8);

        #12;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out_data", out_data, 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Raw pass-through: visible right after the accept edge.
        send(1'b0, 128'hFFEEDDCCBBAA99887766554433221100,
             128'hFFEEDDCCBBAA99887766554433221100, w);
        check("raw_valid", 128'(out_valid), 128'd1);
        check("raw_data", out_data, 128'hFFEEDDCCBBAA99887766554433221100);

        // Three raw flits on consecutive edges.
        send(1'b0, 128'h0123456789ABCDEF0011223344556677, 128'h0123456789ABCDEF0011223344556677, w);
        check("b2b_1_wait", 128'(w), 128'd0);
        send(1'b0, 128'hDEADBEEFCAFEF00D1234567890ABCDEF, 128'hDEADBEEFCAFEF00D1234567890ABCDEF, w);
        check("b2b_2_wait", 128'(w), 128'd0);
        send(1'b0, 128'h5555AAAA5555AAAA5555AAAA5555AAAA, 128'h5555AAAA5555AAAA5555AAAA5555AAAA, w);
        check("b2b_3_wait", 128'(w), 128'd0);
        @(posedge clk);
        #1;

        // Compressed basic with latency profile: busy for 4 cycles, then valid.
        send(1'b1, mk(8'h40, d_basic, 72'h0), 128'h47464544434241404746454443424140, w);
        for (int k = 0; k < 4; k++) begin
            check("expand_out_valid", 128'(out_valid), 128'd0);
            check("expand_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk);
            #1;
        end
        check("expand_done_valid", 128'(out_valid), 128'd1);
        check("expand_done_data", out_data, 128'h47464544434241404746454443424140);
        @(posedge clk);
        #1;

        // Wrap-around of base + delta.
        send(1'b1, mk(8'hFD, 48'hFFFF_FFFF_FFFF, 72'h0), 128'h04040404040404040404040404040404, w);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: result is held stable, input side is blocked.
        out_ready = 1'b0;
        send(1'b1, mk(8'h20, d_basic, 72'h0), 128'h27262524232221202726252423222120, w);
        budget = 20;
        while (!out_valid && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("bp_valid_rise", 128'(out_valid), 128'd1);
        hold_val = 128'h27262524232221202726252423222120;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 128'(out_valid), 128'd1);
            check("bp_hold_data", out_data, hold_val);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        // Handoff and raw accept on the same edge.
        out_ready = 1'b1;
        send(1'b0, 128'hA5A5A5A5000011112222333344445555, 128'hA5A5A5A5000011112222333344445555, w);
        check("handoff_wait", 128'(w), 128'd0);
        check("handoff_valid", 128'(out_valid), 128'd1);
        check("handoff_data", out_data, 128'hA5A5A5A5000011112222333344445555);
        @(posedge clk);
        #1;

        // Reset in the middle of expansion discards the flit.
        send(1'b1, mk(8'h77, 48'hFFFF_FFFF_FFFF, 72'h0), 128'h7E7E7E7E7E7E7E7E7E7E7E7E7E7E7E7E, w);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, mk(8'h10, {16{3'b001}}, 72'h0), 128'h11111111111111111111111111111111, w);
        repeat (6) @(posedge clk);
        #1;

        // Bits above the payload field are ignored.
        send(1'b1, mk(8'h00, 48'h0, {72{1'b1}}), 128'h0, w);
        repeat (6) @(posedge clk);
        #1;
        check("zero_payload_data", out_data, 128'h0);

        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
